stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 37 +++
 rtl/stopwatch_time_counter.sv | 67 ++++++
 rtl/stopwatch_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its time counters.
// The time record packs h/m/s/ms into one 34-bit word so lap entries copy whole.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_RUN   = 2'd1,
    T_PAUSE = 2'd2
  } tmr_state_e;

  localparam int H_W  = 8;
  localparam int M_W  = 8;
  localparam int S_W  = 8;
  localparam int MS_W = 10;

  localparam logic [MS_W-1:0] MS_MAX = 10'd999;
  localparam logic [S_W-1:0]  S_MAX  = 8'd59;
  localparam logic [M_W-1:0]  M_MAX  = 8'd59;

  typedef struct packed {
    logic [H_W-1:0]  h;
    logic [M_W-1:0]  m;
    logic [S_W-1:0]  s;
    logic [MS_W-1:0] ms;
  } time_t;

  // Largest representable time for a given hour ceiling.
  function automatic time_t time_max(input logic [H_W-1:0] hmax);
    time_t t;
    t.h  = hmax;
    t.m  = M_MAX;
    t.s  = S_MAX;
    t.ms = MS_MAX;
    return t;
  endfunction

endpackage

// File: rtl/stopwatch_time_counter.sv
// One h:m:s.ms time counter with same-cycle carry ripple and saturation at
// HOUR_MAX:59:59.999; clear is synchronous and wins over the tick enable.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int HOUR_MAX = 99
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_en,
  input  logic            clear,
  output logic [H_W-1:0]  h,
  output logic [M_W-1:0]  m,
  output logic [S_W-1:0]  s,
  output logic [MS_W-1:0] ms,
  output logic            sat
);

  time_t cnt_r;
  time_t cnt_nxt_s;
  logic  at_max_s;

  assign at_max_s = (cnt_r == time_max(H_W'(HOUR_MAX)));

  // Next count: clear, hold at the ceiling, or increment with carry ripple.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = '0;
    end else if (tick_en && !at_max_s) begin
      if (cnt_r.ms == MS_MAX) begin
        cnt_nxt_s.ms = 10'd0;
        if (cnt_r.s == S_MAX) begin
          cnt_nxt_s.s = 8'd0;
          if (cnt_r.m == M_MAX) begin
            cnt_nxt_s.m = 8'd0;
            cnt_nxt_s.h = cnt_r.h + 8'd1;
          end else begin
            cnt_nxt_s.m = cnt_r.m + 8'd1;
          end
        end else begin
          cnt_nxt_s.s = cnt_r.s + 8'd1;
        end
      end else begin
        cnt_nxt_s.ms = cnt_r.ms + 10'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign h   = cnt_r.h;
  assign m   = cnt_r.m;
  assign s   = cnt_r.s;
  assign ms  = cnt_r.ms;
  assign sat = at_max_s;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: two timer FSMs, shared lap buffer, button arbitration,
// blink generation and registered selection of what the display shows.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = 8,
  parameter int BLINK_MS  = 500,
  parameter int HOUR_MAX  = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1ms,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic        btn_sel,
  input  logic        btn_view,
  output logic [7:0]  hours,
  output logic [7:0]  minutes,
  output logic [7:0]  seconds,
  output logic [9:0]  millisec,
  output logic        view_mode,
  output logic        blink_en,
  output logic        blink_phase,
  output logic        timer_sel,
  output logic        lap_view,
  output logic [3:0]  lap_num,
  output logic        lap_full
);

  localparam logic [3:0] LAP_D      = 4'(LAP_DEPTH);
  localparam int         LAP_SLOTS  = 16;
  localparam int         BC_W       = $clog2(BLINK_MS + 1);
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_MS - 1);

  tmr_state_e tst_r     [2];
  tmr_state_e tst_nxt_s [2];
  tmr_state_e cur_s;
  logic       sel_r, sel_nxt_s;
  logic       lv_r, lv_nxt_s;
  logic [3:0] ln_r, ln_nxt_s;
  logic [3:0] lc_r, lc_nxt_s;
  logic       lap_wr_s;
  logic [1:0] clr_s;
  logic [1:0] tick_en_s;
  logic [1:0] sat_s;
  time_t      t0_s, t1_s, sel_live_s, disp_s;
  // Index space covers all 4-bit lap numbers; slots >= LAP_DEPTH are never written.
  time_t      lap_mem_r [LAP_SLOTS];
  logic       blink_on_s;
  logic [BC_W-1:0] bcnt_r;
  logic       bph_r;

  assign tick_en_s[0] = tick_1ms && (tst_r[0] == T_RUN);
  assign tick_en_s[1] = tick_1ms && (tst_r[1] == T_RUN);

  stopwatch_time_counter #(.HOUR_MAX(HOUR_MAX)) u_cnt0 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en_s[0]), .clear(clr_s[0]),
    .h(t0_s.h), .m(t0_s.m), .s(t0_s.s), .ms(t0_s.ms), .sat(sat_s[0])
  );

  stopwatch_time_counter #(.HOUR_MAX(HOUR_MAX)) u_cnt1 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en_s[1]), .clear(clr_s[1]),
    .h(t1_s.h), .m(t1_s.m), .s(t1_s.s), .ms(t1_s.ms), .sat(sat_s[1])
  );

  assign sel_live_s = sel_r ? t1_s : t0_s;
  assign cur_s      = tst_r[sel_r];
  assign blink_on_s = (cur_s == T_PAUSE) && !lv_r;

  // Button arbitration and next-state: only the highest-priority pulse acts.
  always_comb begin
    tst_nxt_s = tst_r;
    sel_nxt_s = sel_r;
    lv_nxt_s  = lv_r;
    ln_nxt_s  = ln_r;
    lc_nxt_s  = lc_r;
    lap_wr_s  = 1'b0;
    clr_s     = 2'b00;
    if (btn_clear) begin
      if (cur_s == T_PAUSE) begin
        tst_nxt_s[sel_r] = T_IDLE;
        clr_s[sel_r]     = 1'b1;
        lc_nxt_s         = 4'd0;
        lv_nxt_s         = 1'b0;
        ln_nxt_s         = 4'd0;
      end else begin
        clr_s = 2'b00;
      end
    end else if (btn_start) begin
      case (cur_s)
        T_IDLE:  tst_nxt_s[sel_r] = T_RUN;
        T_RUN:   tst_nxt_s[sel_r] = T_PAUSE;
        T_PAUSE: tst_nxt_s[sel_r] = T_RUN;
        default: tst_nxt_s[sel_r] = T_IDLE;
      endcase
    end else if (btn_lap) begin
      if (lv_r) begin
        ln_nxt_s = (ln_r >= lc_r) ? 4'd1 : ln_r + 4'd1;
      end else if ((cur_s == T_RUN) && (lc_r < LAP_D)) begin
        lap_wr_s = 1'b1;
        lc_nxt_s = lc_r + 4'd1;
      end else begin
        lap_wr_s = 1'b0;
      end
    end else if (btn_view) begin
      if (lc_r != 4'd0) begin
        lv_nxt_s = !lv_r;
        ln_nxt_s = lv_r ? 4'd0 : 4'd1;
      end else begin
        lv_nxt_s = lv_r;
      end
    end else if (btn_sel) begin
      sel_nxt_s = !sel_r;
      lv_nxt_s  = 1'b0;
      ln_nxt_s  = 4'd0;
    end else begin
      sel_nxt_s = sel_r;
    end
    // Reaching the ceiling while running forces a pause on that timer.
    for (int i = 0; i < 2; i++) begin
      if (tick_en_s[i] && sat_s[i]) begin
        tst_nxt_s[i] = T_PAUSE;
      end else begin
        tst_nxt_s[i] = tst_nxt_s[i];
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tst_r[0] <= T_IDLE;
      tst_r[1] <= T_IDLE;
      sel_r    <= 1'b0;
      lv_r     <= 1'b0;
      ln_r     <= 4'd0;
      lc_r     <= 4'd0;
    end else begin
      tst_r    <= tst_nxt_s;
      sel_r    <= sel_nxt_s;
      lv_r     <= lv_nxt_s;
      ln_r     <= ln_nxt_s;
      lc_r     <= lc_nxt_s;
    end
  end

  // Lap storage; a clear only resets the count, stale entries are unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAP_SLOTS; i++) begin
        lap_mem_r[i] <= '0;
      end
    end else if (lap_wr_s) begin
      lap_mem_r[lc_r] <= sel_live_s;
    end
  end

  // Blink half-period counter, held in reset whenever blinking is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_r <= '0;
      bph_r  <= 1'b1;
    end else if (!blink_on_s) begin
      bcnt_r <= '0;
      bph_r  <= 1'b1;
    end else if (tick_1ms) begin
      if (bcnt_r == BLINK_LAST) begin
        bcnt_r <= '0;
        bph_r  <= ~bph_r;
      end else begin
        bcnt_r <= bcnt_r + BC_W'(1);
      end
    end
  end

  // Display source selection.
  always_comb begin
    if (lv_r) begin
      disp_s = lap_mem_r[ln_r - 4'd1];
    end else begin
      disp_s = sel_live_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours       <= 8'd0;
      minutes     <= 8'd0;
      seconds     <= 8'd0;
      millisec    <= 10'd0;
      view_mode   <= 1'b1;
      blink_en    <= 1'b0;
      blink_phase <= 1'b1;
      timer_sel   <= 1'b0;
      lap_view    <= 1'b0;
      lap_num     <= 4'd0;
      lap_full    <= 1'b0;
    end else begin
      hours       <= disp_s.h;
      minutes     <= disp_s.m;
      seconds     <= disp_s.s;
      millisec    <= disp_s.ms;
      view_mode   <= (disp_s.h == 8'd0);
      blink_en    <= blink_on_s;
      blink_phase <= bph_r | ~blink_on_s;
      timer_sel   <= sel_r;
      lap_view    <= lv_r;
      lap_num     <= ln_r;
      lap_full    <= (lc_r == LAP_D);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed table-driven bench for stopwatch_ctrl plus hand sequences for
// lap overflow, lap/tick collision, saturation and asynchronous reset.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick_1ms, btn_start, btn_lap, btn_clear, btn_sel, btn_view;
  logic [7:0] hours, minutes, seconds;
  logic [9:0] millisec;
  logic       view_mode, blink_en, blink_phase, timer_sel, lap_view, lap_full;
  logic [3:0] lap_num;
  int         n_tests = 0;
  int         n_fail  = 0;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] CLR  = 5'b10000;
  localparam logic [4:0] STA  = 5'b01000;
  localparam logic [4:0] LAP  = 5'b00100;
  localparam logic [4:0] VIEW = 5'b00010;
  localparam logic [4:0] SEL  = 5'b00001;

  stopwatch_ctrl #(.LAP_DEPTH(8), .BLINK_MS(500), .HOUR_MAX(99)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .btn_sel(btn_sel), .btn_view(btn_view),
    .hours(hours), .minutes(minutes), .seconds(seconds), .millisec(millisec),
    .view_mode(view_mode), .blink_en(blink_en), .blink_phase(blink_phase),
    .timer_sel(timer_sel), .lap_view(lap_view), .lap_num(lap_num),
    .lap_full(lap_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    int ticks;
    int h; int m; int s; int ms;
    int vm; int ben; int bph;
    int sel; int lv; int ln; int lf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [4:0] b);
    {btn_clear, btn_start, btn_lap, btn_view, btn_sel} = b;
    @(negedge clk);
    {btn_clear, btn_start, btn_lap, btn_view, btn_sel} = 5'b00000;
  endtask

  task automatic ticks(input int n);
    if (n > 0) begin
      tick_1ms = 1'b1;
      repeat (n) @(negedge clk);
      tick_1ms = 1'b0;
    end
  endtask

  initial begin
    //          btn        ticks  h  m  s  ms   vm ben bph sel lv ln lf
    vecs[0]  = '{NONE,      0,    0, 0, 0, 0,   1, 0, 1,  0, 0, 0, 0};
    vecs[1]  = '{STA,       1500, 0, 0, 1, 500, 1, 0, 1,  0, 0, 0, 0};
    vecs[2]  = '{STA,       500,  0, 0, 1, 500, 1, 1, 0,  0, 0, 0, 0};
    vecs[3]  = '{NONE,      500,  0, 0, 1, 500, 1, 1, 1,  0, 0, 0, 0};
    vecs[4]  = '{CLR,       0,    0, 0, 0, 0,   1, 0, 1,  0, 0, 0, 0};
    vecs[5]  = '{STA,       100,  0, 0, 0, 100, 1, 0, 1,  0, 0, 0, 0};
    vecs[6]  = '{LAP,       100,  0, 0, 0, 200, 1, 0, 1,  0, 0, 0, 0};
    vecs[7]  = '{LAP,       100,  0, 0, 0, 300, 1, 0, 1,  0, 0, 0, 0};
    vecs[8]  = '{LAP,       100,  0, 0, 0, 400, 1, 0, 1,  0, 0, 0, 0};
    vecs[9]  = '{VIEW,      0,    0, 0, 0, 100, 1, 0, 1,  0, 1, 1, 0};
    vecs[10] = '{LAP,       0,    0, 0, 0, 200, 1, 0, 1,  0, 1, 2, 0};
    vecs[11] = '{LAP,       0,    0, 0, 0, 300, 1, 0, 1,  0, 1, 3, 0};
    vecs[12] = '{LAP,       0,    0, 0, 0, 100, 1, 0, 1,  0, 1, 1, 0};
    vecs[13] = '{SEL,       0,    0, 0, 0, 0,   1, 0, 1,  1, 0, 0, 0};
    vecs[14] = '{STA,       200,  0, 0, 0, 200, 1, 0, 1,  1, 0, 0, 0};
    vecs[15] = '{CLR | STA, 0,    0, 0, 0, 200, 1, 0, 1,  1, 0, 0, 0};
    vecs[16] = '{NONE,      50,   0, 0, 0, 250, 1, 0, 1,  1, 0, 0, 0};
    vecs[17] = '{SEL,       0,    0, 0, 0, 650, 1, 0, 1,  0, 0, 0, 0};

    rst_n = 1'b0;
    tick_1ms = 1'b0;
    {btn_clear, btn_start, btn_lap, btn_view, btn_sel} = 5'b00000;
    step(3);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < NV; i++) begin
      pulse(vecs[i].btn);
      ticks(vecs[i].ticks);
      step(3);
      chk($sformatf("v%0d.hours", i),       int'(hours),       vecs[i].h);
      chk($sformatf("v%0d.minutes", i),     int'(minutes),     vecs[i].m);
      chk($sformatf("v%0d.seconds", i),     int'(seconds),     vecs[i].s);
      chk($sformatf("v%0d.millisec", i),    int'(millisec),    vecs[i].ms);
      chk($sformatf("v%0d.view_mode", i),   int'(view_mode),   vecs[i].vm);
      chk($sformatf("v%0d.blink_en", i),    int'(blink_en),    vecs[i].ben);
      chk($sformatf("v%0d.blink_phase", i), int'(blink_phase), vecs[i].bph);
      chk($sformatf("v%0d.timer_sel", i),   int'(timer_sel),   vecs[i].sel);
      chk($sformatf("v%0d.lap_view", i),    int'(lap_view),    vecs[i].lv);
      chk($sformatf("v%0d.lap_num", i),     int'(lap_num),     vecs[i].ln);
      chk($sformatf("v%0d.lap_full", i),    int'(lap_full),    vecs[i].lf);
    end

    // Empty the lap buffer, then overflow it: laps at 0,10,..,80 ms, ninth dropped.
    pulse(STA);
    pulse(CLR);
    step(3);
    chk("clr.lap_full", int'(lap_full), 0);
    chk("clr.millisec", int'(millisec), 0);
    pulse(VIEW);
    step(3);
    chk("view_empty.lap_view", int'(lap_view), 0);
    pulse(STA);
    for (int k = 0; k < 9; k++) begin
      pulse(LAP);
      ticks(10);
    end
    step(3);
    chk("full.lap_full", int'(lap_full), 1);
    chk("full.millisec", int'(millisec), 90);
    pulse(VIEW);
    step(3);
    chk("full.view_lap_num", int'(lap_num), 1);
    chk("full.view_ms", int'(millisec), 0);
    repeat (7) pulse(LAP);
    step(3);
    chk("full.lap8_num", int'(lap_num), 8);
    chk("full.lap8_ms", int'(millisec), 70);
    pulse(LAP);
    step(3);
    chk("full.wrap_num", int'(lap_num), 1);

    // Clear while paused in lap view empties buffer and leaves lap view.
    pulse(STA);
    pulse(CLR);
    step(3);
    chk("vclr.lap_view", int'(lap_view), 0);
    chk("vclr.lap_num", int'(lap_num), 0);
    chk("vclr.lap_full", int'(lap_full), 0);
    chk("vclr.blink_en", int'(blink_en), 0);

    // Lap and tick in the same cycle record the pre-increment value.
    pulse(STA);
    ticks(5);
    btn_lap = 1'b1;
    tick_1ms = 1'b1;
    @(negedge clk);
    btn_lap = 1'b0;
    tick_1ms = 1'b0;
    pulse(VIEW);
    step(3);
    chk("laptick.lap_ms", int'(millisec), 5);
    chk("laptick.lap_num", int'(lap_num), 1);
    pulse(VIEW);
    step(3);
    chk("laptick.live_ms", int'(millisec), 6);
    chk("laptick.lap_view", int'(lap_view), 0);

    // Hour carry from 0:59:59.999.
    force dut.u_cnt0.cnt_r = {8'd0, 8'd59, 8'd59, 10'd999};
    #1;
    release dut.u_cnt0.cnt_r;
    tick_1ms = 1'b1;
    @(negedge clk);
    tick_1ms = 1'b0;
    step(3);
    chk("carry.hours", int'(hours), 1);
    chk("carry.minutes", int'(minutes), 0);
    chk("carry.seconds", int'(seconds), 0);
    chk("carry.millisec", int'(millisec), 0);
    chk("carry.view_mode", int'(view_mode), 0);

    // Saturation at 99:59:59.999 holds the value and pauses the timer.
    force dut.u_cnt0.cnt_r = {8'd99, 8'd59, 8'd59, 10'd999};
    #1;
    release dut.u_cnt0.cnt_r;
    tick_1ms = 1'b1;
    @(negedge clk);
    tick_1ms = 1'b0;
    step(3);
    chk("sat.hours", int'(hours), 99);
    chk("sat.minutes", int'(minutes), 59);
    chk("sat.seconds", int'(seconds), 59);
    chk("sat.millisec", int'(millisec), 999);
    chk("sat.blink_en", int'(blink_en), 1);
    pulse(STA);
    ticks(20);
    step(3);
    chk("sat2.millisec", int'(millisec), 999);
    chk("sat2.hours", int'(hours), 99);
    chk("sat2.blink_en", int'(blink_en), 1);

    // Asynchronous reset mid-count returns outputs to reset values at once.
    pulse(STA);
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk("rst.hours", int'(hours), 0);
    chk("rst.millisec", int'(millisec), 0);
    chk("rst.view_mode", int'(view_mode), 1);
    chk("rst.blink_en", int'(blink_en), 0);
    chk("rst.blink_phase", int'(blink_phase), 1);
    chk("rst.lap_view", int'(lap_view), 0);
    chk("rst.timer_sel", int'(timer_sel), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
